// File: rtl/mips_ctrl_pkg.sv
// Shared opcode constants, ALUOp encodings and control-bundle types for the
// pipelined MIPS main control unit.
package mips_ctrl_pkg;

    localparam int unsigned OPC_W = 6;
    localparam int unsigned ALU_W = 2;
    localparam int unsigned REG_W = 5;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALU_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [ALU_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [ALU_W-1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic             regdst;
        logic [ALU_W-1:0] aluop;
        logic             alusrc;
    } ex_ctrl_t;

    typedef struct packed {
        logic branch;
        logic memread;
        logic memwrite;
    } m_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    localparam int unsigned EX_W = $bits(ex_ctrl_t);
    localparam int unsigned M_W  = $bits(m_ctrl_t);
    localparam int unsigned WB_W = $bits(wb_ctrl_t);

    localparam ex_ctrl_t EX_ZERO = '0;
    localparam m_ctrl_t  M_ZERO  = '0;
    localparam wb_ctrl_t WB_ZERO = '0;

endpackage

// File: rtl/mips_main_decoder.sv
// Combinational main decoder: ID opcode to EX/M/WB control bundles plus
// jump, illegal-opcode and rt-is-a-source flags.
module mips_main_decoder
    import mips_ctrl_pkg::*;
(
    input  logic             i_valid,
    input  logic [OPC_W-1:0] i_op,
    output logic [EX_W-1:0]  o_ex,
    output logic [M_W-1:0]   o_m,
    output logic [WB_W-1:0]  o_wb,
    output logic             o_jump,
    output logic             o_illegal,
    output logic             o_uses_rt
);

    ex_ctrl_t w_ex;
    m_ctrl_t  w_m;
    wb_ctrl_t w_wb;

    always_comb begin
        w_ex      = EX_ZERO;
        w_m       = M_ZERO;
        w_wb      = WB_ZERO;
        o_jump    = 1'b0;
        o_illegal = 1'b0;
        o_uses_rt = 1'b0;
        if (i_valid) begin
            case (i_op)
                OP_RTYPE: begin
                    w_ex      = '{regdst: 1'b1, aluop: ALU_FUNCT, alusrc: 1'b0};
                    w_wb      = '{regwrite: 1'b1, memtoreg: 1'b0};
                    o_uses_rt = 1'b1;
                end
                OP_LW: begin
                    w_ex = '{regdst: 1'b0, aluop: ALU_ADD, alusrc: 1'b1};
                    w_m  = '{branch: 1'b0, memread: 1'b1, memwrite: 1'b0};
                    w_wb = '{regwrite: 1'b1, memtoreg: 1'b1};
                end
                OP_SW: begin
                    w_ex      = '{regdst: 1'b0, aluop: ALU_ADD, alusrc: 1'b1};
                    w_m       = '{branch: 1'b0, memread: 1'b0, memwrite: 1'b1};
                    o_uses_rt = 1'b1;
                end
                OP_BEQ: begin
                    w_ex      = '{regdst: 1'b0, aluop: ALU_SUB, alusrc: 1'b0};
                    w_m       = '{branch: 1'b1, memread: 1'b0, memwrite: 1'b0};
                    o_uses_rt = 1'b1;
                end
                OP_ADDI: begin
                    w_ex = '{regdst: 1'b0, aluop: ALU_ADD, alusrc: 1'b1};
                    w_wb = '{regwrite: 1'b1, memtoreg: 1'b0};
                end
                OP_J:    o_jump    = 1'b1;
                default: o_illegal = 1'b1;
            endcase
        end
    end

    assign o_ex = w_ex;
    assign o_m  = w_m;
    assign o_wb = w_wb;

endmodule

// File: rtl/mips_ctrl_pipe.sv
// Pipelined main control: decodes in ID and carries control bundles through
// ID/EX, EX/MEM and MEM/WB with load-use bubbles, external freeze and flush.
module mips_ctrl_pipe
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OP_W      = 6,
    parameter int unsigned ALUOP_W   = 2,
    parameter int unsigned RADDR_W   = 5,
    parameter int unsigned HAZARD_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [OP_W-1:0]    id_op,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic               stall_ext,
    input  logic               flush,
    output logic               id_jump,
    output logic               hazard_stall,
    output logic               ex_regdst,
    output logic               ex_alusrc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [RADDR_W-1:0] ex_rt,
    output logic               ex_illegal,
    output logic               mem_branch,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic               wb_regwrite,
    output logic               wb_memtoreg
);

    ex_ctrl_t w_id_ex;
    m_ctrl_t  w_id_m;
    wb_ctrl_t w_id_wb;
    logic     w_id_illegal;
    logic     w_uses_rt;
    logic     w_hazard;

    ex_ctrl_t           r_ex_ex;
    m_ctrl_t            r_ex_m;
    wb_ctrl_t           r_ex_wb;
    logic [RADDR_W-1:0] r_ex_rt;
    logic               r_ex_illegal;
    m_ctrl_t            r_mem_m;
    wb_ctrl_t           r_mem_wb;
    wb_ctrl_t           r_wb_wb;

    mips_main_decoder u_decoder (
        .i_valid   (id_valid),
        .i_op      (id_op),
        .o_ex      (w_id_ex),
        .o_m       (w_id_m),
        .o_wb      (w_id_wb),
        .o_jump    (id_jump),
        .o_illegal (w_id_illegal),
        .o_uses_rt (w_uses_rt)
    );

    // Load in EX whose destination feeds the instruction currently in ID.
    assign w_hazard = (HAZARD_EN != 0) && id_valid && r_ex_m.memread && (r_ex_rt != '0) &&
                      ((r_ex_rt == id_rs) || (w_uses_rt && (r_ex_rt == id_rt)));
    assign hazard_stall = w_hazard && !flush && !stall_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_ex      <= EX_ZERO;
            r_ex_m       <= M_ZERO;
            r_ex_wb      <= WB_ZERO;
            r_ex_rt      <= '0;
            r_ex_illegal <= 1'b0;
            r_mem_m      <= M_ZERO;
            r_mem_wb     <= WB_ZERO;
            r_wb_wb      <= WB_ZERO;
        end else if (!stall_ext) begin
            r_wb_wb <= r_mem_wb;
            if (flush) begin
                r_mem_m  <= M_ZERO;
                r_mem_wb <= WB_ZERO;
            end else begin
                r_mem_m  <= r_ex_m;
                r_mem_wb <= r_ex_wb;
            end
            if (flush || hazard_stall) begin
                r_ex_ex      <= EX_ZERO;
                r_ex_m       <= M_ZERO;
                r_ex_wb      <= WB_ZERO;
                r_ex_rt      <= '0;
                r_ex_illegal <= 1'b0;
            end else begin
                r_ex_ex      <= w_id_ex;
                r_ex_m       <= w_id_m;
                r_ex_wb      <= w_id_wb;
                r_ex_rt      <= id_valid ? id_rt : '0;
                r_ex_illegal <= w_id_illegal;
            end
        end
    end

    assign ex_regdst    = r_ex_ex.regdst;
    assign ex_alusrc    = r_ex_ex.alusrc;
    assign ex_aluop     = r_ex_ex.aluop;
    assign ex_rt        = r_ex_rt;
    assign ex_illegal   = r_ex_illegal;
    assign mem_branch   = r_mem_m.branch;
    assign mem_memread  = r_mem_m.memread;
    assign mem_memwrite = r_mem_m.memwrite;
    assign wb_regwrite  = r_wb_wb.regwrite;
    assign wb_memtoreg  = r_wb_wb.memtoreg;

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// Bench for mips_ctrl_pipe: directed and random instruction streams checked
// against an instruction-level pipeline model.
module tb_mips_ctrl_pipe;

    localparam bit [5:0] OP_R    = 6'b000000;
    localparam bit [5:0] OP_LW   = 6'b100011;
    localparam bit [5:0] OP_SW   = 6'b101011;
    localparam bit [5:0] OP_BEQ  = 6'b000100;
    localparam bit [5:0] OP_ADDI = 6'b001000;
    localparam bit [5:0] OP_J    = 6'b000010;
    localparam bit [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst, id_valid, stall_ext, flush;
    logic [5:0] id_op;
    logic [4:0] id_rs, id_rt;
    logic       id_jump, hazard_stall;
    logic       ex_regdst, ex_alusrc, ex_illegal;
    logic [1:0] ex_aluop;
    logic [4:0] ex_rt;
    logic       mem_branch, mem_memread, mem_memwrite;
    logic       wb_regwrite, wb_memtoreg;

    always #5 clk = ~clk;

    mips_ctrl_pipe #(
        .OP_W      (6),
        .ALUOP_W   (2),
        .RADDR_W   (5),
        .HAZARD_EN (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_op        (id_op),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .stall_ext    (stall_ext),
        .flush        (flush),
        .id_jump      (id_jump),
        .hazard_stall (hazard_stall),
        .ex_regdst    (ex_regdst),
        .ex_alusrc    (ex_alusrc),
        .ex_aluop     (ex_aluop),
        .ex_rt        (ex_rt),
        .ex_illegal   (ex_illegal),
        .mem_branch   (mem_branch),
        .mem_memread  (mem_memread),
        .mem_memwrite (mem_memwrite),
        .wb_regwrite  (wb_regwrite),
        .wb_memtoreg  (wb_memtoreg)
    );

    // One in-flight instruction per stage; v=0 is a bubble.
    typedef struct {
        bit       v;
        bit [5:0] op;
        bit [4:0] rt;
    } slot_t;

    slot_t s_ex, s_mem, s_wb;
    int n_cmp  = 0;
    int n_fail = 0;

    // {regdst, aluop[1:0], alusrc, branch, memread, memwrite, regwrite, memtoreg, illegal}
    function automatic bit [9:0] ctrl_of(slot_t s);
        if (!s.v) return 10'b0;
        case (s.op)
            OP_R:    return 10'b1_10_0_000_10_0;
            OP_LW:   return 10'b0_00_1_010_11_0;
            OP_SW:   return 10'b0_00_1_001_00_0;
            OP_BEQ:  return 10'b0_01_0_100_00_0;
            OP_ADDI: return 10'b0_00_1_000_10_0;
            OP_J:    return 10'b0;
            default: return 10'b0_00_0_000_00_1;
        endcase
    endfunction

    function automatic bit reads_rt(bit [5:0] op);
        return (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(bit r, bit v, bit [5:0] op, bit [4:0] rs, bit [4:0] rt,
                         bit st, bit fl);
        bit [9:0] ce, cm, cw;
        bit       hz;
        slot_t    bub;
        slot_t    id;
        bub = '{v: 1'b0, op: 6'd0, rt: 5'd0};
        id  = '{v: v, op: op, rt: rt};
        rst = r; id_valid = v; id_op = op; id_rs = rs; id_rt = rt;
        stall_ext = st; flush = fl;
        #2;
        ce = ctrl_of(s_ex);
        cm = ctrl_of(s_mem);
        cw = ctrl_of(s_wb);
        hz = s_ex.v && (s_ex.op == OP_LW) && (s_ex.rt != 0) && v &&
             ((s_ex.rt == rs) || (reads_rt(op) && (s_ex.rt == rt)));
        chk("ex_ctrl", 16'({ex_regdst, ex_aluop, ex_alusrc, ex_illegal}),
            16'({ce[9:6], ce[0]}));
        chk("ex_rt", 16'(ex_rt), 16'(s_ex.v ? s_ex.rt : 5'd0));
        chk("mem_ctrl", 16'({mem_branch, mem_memread, mem_memwrite}), 16'(cm[5:3]));
        chk("wb_ctrl", 16'({wb_regwrite, wb_memtoreg}), 16'(cw[2:1]));
        chk("id_jump", 16'(id_jump), 16'(v && (op == OP_J)));
        chk("hazard_stall", 16'(hazard_stall), 16'(hz && !fl && !st));
        @(posedge clk);
        if (r) begin
            s_ex = bub; s_mem = bub; s_wb = bub;
        end else if (!st) begin
            s_wb = s_mem;
            if (fl) begin
                s_mem = bub; s_ex = bub;
            end else if (hz) begin
                s_mem = s_ex; s_ex = bub;
            end else begin
                s_mem = s_ex; s_ex = id;
            end
        end
        #2;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, OP_R, 0, 0, 0, 0);
    endtask

    initial begin
        bit [5:0] ops[7];
        bit [5:0] op;
        int unsigned p;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BAD};
        rst = 1'b1; id_valid = 1'b0; id_op = '0; id_rs = '0; id_rt = '0;
        stall_ext = 1'b0; flush = 1'b0;
        @(posedge clk);
        #2;
        s_ex = '{v: 1'b0, op: 6'd0, rt: 5'd0};
        s_mem = s_ex;
        s_wb = s_ex;

        // Back-to-back decode of each class.
        cycle(0, 1, OP_R, 1, 2, 0, 0);
        cycle(0, 1, OP_LW, 3, 7, 0, 0);
        cycle(0, 1, OP_SW, 1, 2, 0, 0);
        cycle(0, 1, OP_BEQ, 1, 2, 0, 0);
        cycle(0, 1, OP_ADDI, 1, 2, 0, 0);
        idle(3);

        // Load-use: one bubble, R-type re-presented while IF/ID holds.
        cycle(0, 1, OP_LW, 1, 5, 0, 0);
        cycle(0, 1, OP_R, 5, 6, 0, 0);
        cycle(0, 1, OP_R, 5, 6, 0, 0);
        idle(3);
        cycle(0, 1, OP_LW, 1, 4, 0, 0);
        cycle(0, 1, OP_SW, 2, 4, 0, 0);
        cycle(0, 1, OP_SW, 2, 4, 0, 0);
        idle(2);
        cycle(0, 1, OP_LW, 1, 0, 0, 0);
        cycle(0, 1, OP_R, 0, 0, 0, 0);
        idle(3);

        // Flush with sw in EX/MEM and beq in ID/EX.
        cycle(0, 1, OP_ADDI, 1, 3, 0, 0);
        cycle(0, 1, OP_SW, 1, 2, 0, 0);
        cycle(0, 1, OP_BEQ, 1, 2, 0, 0);
        cycle(0, 1, OP_R, 1, 2, 0, 1);
        idle(3);

        // External freeze for three cycles, flush inside it ignored.
        cycle(0, 1, OP_R, 1, 2, 0, 0);
        cycle(0, 1, OP_LW, 1, 4, 0, 0);
        cycle(0, 1, OP_ADDI, 1, 2, 1, 0);
        cycle(0, 1, OP_ADDI, 1, 2, 1, 1);
        cycle(0, 1, OP_ADDI, 1, 2, 1, 0);
        cycle(0, 1, OP_ADDI, 1, 2, 0, 0);
        idle(3);

        // Illegal opcode and jump.
        cycle(0, 1, OP_BAD, 1, 2, 0, 0);
        cycle(0, 1, OP_J, 1, 2, 0, 0);
        idle(3);

        // Reset with lw in MEM.
        cycle(0, 1, OP_LW, 1, 3, 0, 0);
        cycle(0, 1, OP_R, 1, 2, 0, 0);
        cycle(1, 0, OP_R, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            p  = $urandom_range(0, 7);
            op = (p == 7) ? 6'($urandom) : ops[p];
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0, op,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_ctrl_pipe.md
Name: mips_ctrl_pipe

Overview:
Pipelined main control unit for the 5-stage MIPS datapath. Decodes the ID-stage opcode into EX/M/WB control bundles and carries them through the ID/EX, EX/MEM and MEM/WB control registers. Adds load-use hazard detection with bubble insertion, external stall (freeze) and branch flush. It sits beside the datapath pipeline registers and drives every stage's control inputs.

Parameters:
OP_W, 6, opcode width
ALUOP_W, 2, ALUOp field width (00 add, 01 sub, 10 funct-decoded)
RADDR_W, 5, register-address width
HAZARD_EN, 1, 1 = load-use detection active; 0 = hazard_stall tied 0

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
id_valid  in  1  ID stage holds a real instruction
id_op  in  OP_W  opcode in ID
id_rs  in  RADDR_W  rs field in ID
id_rt  in  RADDR_W  rt field in ID
stall_ext  in  1  freeze all control registers (memory wait)
flush  in  1  branch taken; kill ID/EX and EX/MEM contents
id_jump  out  1  combinational: id_valid && op==j
hazard_stall  out  1  combinational: hold PC and IF/ID, bubble into ID/EX
ex_regdst, ex_alusrc  out  1 each  EX controls
ex_aluop  out  ALUOP_W  EX ALU operation class
ex_rt  out  RADDR_W  rt captured with the EX bundle
ex_illegal  out  1  instruction now in EX had an undecoded opcode
mem_branch, mem_memread, mem_memwrite  out  1 each  MEM controls
wb_regwrite, wb_memtoreg  out  1 each  WB controls

Behaviour:
- Decode (combinational) as RegDst,ALUOp,ALUSrc / Branch,MemRead,MemWrite / RegWrite,MemtoReg:
  R-type 000000: 1,10,0 / 0,0,0 / 1,0
  lw 100011: 0,00,1 / 0,1,0 / 1,1
  sw 101011: 0,00,1 / 0,0,1 / 0,0
  beq 000100: 0,01,0 / 1,0,0 / 0,0
  addi 001000: 0,00,1 / 0,0,0 / 1,0
  j 000010: all 0; id_jump=1
  other: all 0; illegal=1
- id_valid=0 decodes to all-zero bundle with illegal=0.
- Latency: instruction in ID at cycle n → ex_* valid n+1, mem_* n+2, wb_* n+3.
- Reset: all registered outputs 0 on the first rising edge with rst=1. rst mid-stream discards all in-flight bundles.
- Per-edge priority: rst > stall_ext > flush > hazard > normal advance.
- stall_ext=1: all three registers hold, including ex_rt and ex_illegal. hazard_stall is still computed from the held state. A flush during stall is ignored; the requester holds flush until stall_ext falls.
- flush=1 (no stall): ID/EX and EX/MEM load zero bundles. MEM/WB loads the old EX/MEM normally, so the instruction already past MEM retires.
- hazard = HAZARD_EN && id_valid && ex_memread_reg && ex_rt!=0 && (ex_rt==id_rs || (uses_rt && ex_rt==id_rt)).
  - uses_rt covers R-type, sw and beq.
  - ex_memread_reg is the registered M bundle in ID/EX.
- hazard_stall = hazard && !flush && !stall_ext.
- On hazard_stall: ID/EX loads a zero bundle and ex_rt=0. EX/MEM and MEM/WB advance. The next cycle re-evaluates with the lw now in MEM, so hazard clears and the stall lasts exactly one cycle.
- Register 0 as destination never causes a stall.
- Zero bundles have no side effects (no write, no memory access).

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - ALUOp encodings (ALU_ADD, ALU_SUB, ALU_FUNCT)
  - bundle widths and zero-bundle constants
- Sub-module mips_main_decoder: purely combinational opcode → {EX, M, WB, jump, illegal, uses_rt}. It is instantiated once; pipeline registers, hazard logic and priority live in mips_ctrl_pipe.

Test Plan:
- Reset then issue R-type, lw, sw, beq, addi on consecutive cycles → each bundle appears at EX n+1, MEM n+2, WB n+3 with the decode values above (e.g. lw: ex_alusrc=1, mem_memread=1, wb_memtoreg=1).
- lw rt=5 followed by R-type rs=5 → hazard_stall=1 for exactly one cycle. A zero bundle appears at EX. The R-type bundle reaches EX one cycle late. lw rt=0 → no stall.
- sw in EX/MEM, beq in ID/EX, flush=1 → next cycle ex_*/mem_* all 0. The sw bundle reaches WB stage (wb_regwrite=0); the prior MEM instruction retires.
- stall_ext=1 for 3 cycles mid-stream → all outputs constant. On release, the pipeline resumes with no bundle lost or duplicated. flush asserted during the stall has no effect.
- Opcode 111111 and j → ex_illegal=1 for 111111, id_jump=1 for j, all other controls 0. rst asserted with lw in MEM → all outputs 0 next cycle.
